// File: rtl/golden_nonce_uart_tx.sv
// Queues newly reported golden nonces and sends each one MSB byte first over an 8N1 UART line.
// Build option: CONFIG_TX_SYNC_BYTE_EN prefixes every packet with a 0x55 sync byte.
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV  = 434,
    parameter int FIFO_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] golden_nonce,
    output logic        tx_serial,
    output logic        tx_busy,
    output logic        overflow
);

    localparam int          DEPTH       = 1 << FIFO_LOG2;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
`ifdef CONFIG_TX_SYNC_BYTE_EN
    localparam logic [2:0]  LAST_BYTE   = 3'd4;
`else
    localparam logic [2:0]  LAST_BYTE   = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        baud_reg, baud_next;
    logic [2:0]         bit_reg, bit_next;
    logic [2:0]         byte_reg, byte_next;
    logic [31:0]        pkt_reg, pkt_next;
    logic [31:0]        nonce_prev_reg;
    logic               overflow_reg;
    logic [FIFO_LOG2:0] wr_ptr_reg, rd_ptr_reg;
    logic [31:0]        mem [DEPTH];

    logic               fifo_empty, fifo_full;
    logic               new_nonce, push, pop, drop;
    logic [7:0]         cur_byte;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_LOG2] != rd_ptr_reg[FIFO_LOG2]) &&
                        (wr_ptr_reg[FIFO_LOG2-1:0] == rd_ptr_reg[FIFO_LOG2-1:0]);

    assign new_nonce = (golden_nonce != nonce_prev_reg) && (golden_nonce != 32'd0);
    assign pop       = (state_reg == IDLE) && !fifo_empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept the new nonce.
    assign push      = new_nonce && (!fifo_full || pop);
    assign drop      = new_nonce && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[FIFO_LOG2-1:0]] <= golden_nonce;
        end
    end

    always_comb begin
        cur_byte = pkt_reg[7:0];
`ifdef CONFIG_TX_SYNC_BYTE_EN
        case (byte_reg)
            3'd0:    cur_byte = 8'h55;
            3'd1:    cur_byte = pkt_reg[31:24];
            3'd2:    cur_byte = pkt_reg[23:16];
            3'd3:    cur_byte = pkt_reg[15:8];
            default: cur_byte = pkt_reg[7:0];
        endcase
`else
        case (byte_reg)
            3'd0:    cur_byte = pkt_reg[31:24];
            3'd1:    cur_byte = pkt_reg[23:16];
            3'd2:    cur_byte = pkt_reg[15:8];
            default: cur_byte = pkt_reg[7:0];
        endcase
`endif
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        pkt_next   = pkt_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pkt_next   = mem[rd_ptr_reg[FIFO_LOG2-1:0]];
                    byte_next  = 3'd0;
                    baud_next  = BAUD_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == 16'd0) begin
                    baud_next  = BAUD_RELOAD;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            DATA: begin
                if (baud_reg == 16'd0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            STOP: begin
                if (baud_reg == 16'd0) begin
                    if (byte_reg == LAST_BYTE) begin
                        state_next = IDLE;
                    end else begin
                        byte_next  = byte_reg + 3'd1;
                        baud_next  = BAUD_RELOAD;
                        state_next = START;
                    end
                end else begin
                    baud_next = baud_reg - 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            baud_reg       <= 16'd0;
            bit_reg        <= 3'd0;
            byte_reg       <= 3'd0;
            pkt_reg        <= 32'd0;
            nonce_prev_reg <= 32'd0;
            overflow_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_reg        <= bit_next;
            byte_reg       <= byte_next;
            pkt_reg        <= pkt_next;
            nonce_prev_reg <= golden_nonce;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Line level is decoded from the state so an asynchronous reset forces it high at once.
    always_comb begin
        tx_serial = 1'b1;
        case (state_reg)
            START:   tx_serial = 1'b0;
            DATA:    tx_serial = cur_byte[bit_reg];
            default: tx_serial = 1'b1;
        endcase
    end

    assign tx_busy  = (state_reg != IDLE) || !fifo_empty;
    assign overflow = overflow_reg;

endmodule
